dmem_resp: RTL



---
 rtl/dmem_resp.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder for the CPU MEM stage: word RAM with byte-lane writes,
// read-first full-word reads and a programmable number of stall cycles per access.
module dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_daddr_in,
  input  logic [3:0]  mem_dwe_in,
  input  logic [31:0] mem_dwdata_in,
  input  logic        mem_dre_in,
  output logic [31:0] mem_drdata_out,
  output logic        mem_rvalid_out,
  output logic        mem_err_out,
  output logic        mem_stall_out
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [29:0] widx_reg;
  logic [3:0]  dwe_reg;
  logic [31:0] wdata_reg;
  logic        rvalid_reg, err_reg;
  logic [31:0] rd_word;

  logic        req, access, stall, use_latched, in_range;
  logic [29:0] acc_widx;
  logic [3:0]  acc_dwe;
  logic [31:0] acc_wdata;
  logic [AW-1:0] ram_idx;
  logic        addr_lsb_unused;

  // Byte offset is irrelevant: the block always works on whole aligned words.
  assign addr_lsb_unused = ^mem_daddr_in[1:0];

  assign req = mem_dre_in | (|mem_dwe_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (req && (WAIT_CYCLES != 0)) begin
          state_next = S_WAIT;
          cnt_next   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    access      = 1'b0;
    use_latched = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            if (WAIT_CYCLES == 0) access = 1'b1;
            else                  stall  = 1'b1;
          end
        end
        S_WAIT: begin
          use_latched = 1'b1;
          if (cnt_reg == 3'd1) access = 1'b1;
          else                 stall  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_stall_out = stall;

  // Capture the request when it is first seen; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state_reg == S_IDLE && req) begin
      widx_reg  <= mem_daddr_in[31:2];
      dwe_reg   <= mem_dwe_in;
      wdata_reg <= mem_dwdata_in;
    end
  end

  assign acc_widx  = use_latched ? widx_reg  : mem_daddr_in[31:2];
  assign acc_dwe   = use_latched ? dwe_reg   : mem_dwe_in;
  assign acc_wdata = use_latched ? wdata_reg : mem_dwdata_in;
  assign in_range  = ({2'b00, acc_widx} < 32'(DEPTH_WORDS));
  assign ram_idx   = acc_widx[AW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram [DEPTH_WORDS];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (access && in_range && acc_dwe[gi])
          ram[ram_idx] <= acc_wdata[8*gi +: 8];
      end

      // Read-first: the old byte is captured on the same edge that writes the new one.
      always_ff @(posedge clk) begin
        if (reset)
          rd_byte_reg <= 8'h00;
        else if (access)
          rd_byte_reg <= in_range ? ram[ram_idx] : 8'h00;
      end

      assign rd_word[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      rvalid_reg <= access;
      err_reg    <= access & ~in_range;
    end
  end

  assign mem_drdata_out = rd_word;
  assign mem_rvalid_out = rvalid_reg;
  assign mem_err_out    = err_reg;

endmodule
